// File: rtl/m_mem_arbiter.sv
// Two-requester memory arbiter: round-robin on ties, locked bursts capped at MAX_BURST
// while the other side waits, single-cycle access with registered read return.
module m_mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic        i_lock0,
  input  logic        i_lock1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e      r_state;
  logic        r_ptr;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_rvalid0;
  logic        r_rvalid1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic [3:0]  w_cnt_post;
  logic        w_cap;
  logic        w_other_req;
  logic        w_keep;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_reset) begin
      unique case (r_state)
        StIdle: begin
          // r_ptr is the last-served index; on a tie the other one wins
          if (i_req0 && i_req1) begin
            w_gnt0 = r_ptr;
            w_gnt1 = ~r_ptr;
          end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
          end
        end
        StLock0: w_gnt0 = i_req0;
        StLock1: w_gnt1 = i_req1;
        default: ;
      endcase
    end
  end

  // w_cnt_post counts consecutive locked grants including the current one
  always_comb begin
    w_any_gnt   = w_gnt0 | w_gnt1;
    w_cnt_post  = (r_state == StIdle) ? 4'd1 : ((r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1);
    w_cap       = 32'(w_cnt_post) >= MAX_BURST;
    w_other_req = w_gnt0 ? i_req1 : i_req0;
    w_keep      = (w_gnt0 ? i_lock0 : i_lock1) && !(w_cap && w_other_req);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_ptr     <= 1'b1;
      r_cnt     <= 4'd0;
      r_rdata0  <= 32'd0;
      r_rdata1  <= 32'd0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~i_we0;
      r_rvalid1 <= w_gnt1 & ~i_we1;
      if (w_gnt0 && !i_we0) r_rdata0 <= i_mem_rd;
      if (w_gnt1 && !i_we1) r_rdata1 <= i_mem_rd;
      if (w_any_gnt) r_ptr <= w_gnt1;
      if (w_any_gnt && w_keep) begin
        r_state <= w_gnt0 ? StLock0 : StLock1;
        r_cnt   <= w_cnt_post;
      end else begin
        r_state <= StIdle;
        r_cnt   <= 4'd0;
      end
    end
  end

  assign o_gnt0     = w_gnt0;
  assign o_gnt1     = w_gnt1;
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_rvalid0  = r_rvalid0;
  assign o_rvalid1  = r_rvalid1;
  assign o_mem_we   = w_gnt0 ? i_we0    : (w_gnt1 ? i_we1    : 1'b0);
  assign o_mem_addr = w_gnt0 ? i_addr0  : (w_gnt1 ? i_addr1  : 32'd0);
  assign o_mem_wd   = w_gnt0 ? i_wdata0 : (w_gnt1 ? i_wdata1 : 32'd0);

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter: per-cycle grant/bus checks plus a read-return
// scoreboard fed from a reference memory the bench updates on expected grants.
module tb_m_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req0, i_req1, i_we0, i_we1, i_lock0, i_lock1;
  logic [31:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_mem_we;
  logic [31:0] o_rdata0, o_rdata1, o_mem_addr, o_mem_wd, i_mem_rd;

  logic [31:0] env_mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] exp_rd0, exp_rd1;
  logic        prev_rst;
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  m_mem_arbiter #(.MAX_BURST(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_lock0(i_lock0), .i_lock1(i_lock1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd), .i_mem_rd(i_mem_rd)
  );

  // Environment memory, driven only by the DUT's memory port
  assign i_mem_rd = env_mem[o_mem_addr[7:2]];
  always @(posedge clk) if (o_mem_we) env_mem[o_mem_addr[7:2]] <= o_mem_wd;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
  endtask

  // One clock cycle: check last cycle's read return, drive inputs, check grant and bus.
  task automatic step(input logic rst,
                      input logic rq0, input logic we0, input logic lk0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic rq1, input logic we1, input logic lk1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1);
    @(posedge clk);
    #1;
    if (prev_rst) begin
      q0.delete();
      q1.delete();
      exp_rd0 = 32'd0;
      exp_rd1 = 32'd0;
    end
    chk("rvalid0", 32'(o_rvalid0), 32'(q0.size() != 0));
    if (q0.size() != 0) exp_rd0 = q0.pop_front();
    chk("rdata0", o_rdata0, exp_rd0);
    chk("rvalid1", 32'(o_rvalid1), 32'(q1.size() != 0));
    if (q1.size() != 0) exp_rd1 = q1.pop_front();
    chk("rdata1", o_rdata1, exp_rd1);
    prev_rst = rst;
    i_reset = rst;
    i_req0 = rq0; i_we0 = we0; i_lock0 = lk0; i_addr0 = a0; i_wdata0 = d0;
    i_req1 = rq1; i_we1 = we1; i_lock1 = lk1; i_addr1 = a1; i_wdata1 = d1;
    #1;
    chk("gnt0", 32'(o_gnt0), 32'(eg0));
    chk("gnt1", 32'(o_gnt1), 32'(eg1));
    chk("mem_we", 32'(o_mem_we), 32'(eg0 ? we0 : (eg1 ? we1 : 1'b0)));
    chk("mem_addr", o_mem_addr, eg0 ? a0 : (eg1 ? a1 : 32'd0));
    chk("mem_wd", o_mem_wd, eg0 ? d0 : (eg1 ? d1 : 32'd0));
    if (eg0) begin
      if (we0) ref_mem[a0[7:2]] = d0;
      else q0.push_back(ref_mem[a0[7:2]]);
    end
    if (eg1) begin
      if (we1) ref_mem[a1[7:2]] = d1;
      else q1.push_back(ref_mem[a1[7:2]]);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'h5000_0000 + 32'(i);
      ref_mem[i] = 32'h5000_0000 + 32'(i);
    end
    env_mem[4] = 32'hAAAA_0000; ref_mem[4] = 32'hAAAA_0000;
    env_mem[8] = 32'hBBBB_0000; ref_mem[8] = 32'hBBBB_0000;
    exp_rd0 = 32'd0;
    exp_rd1 = 32'd0;
    prev_rst = 1'b1;
    i_reset = 1'b1;
    i_req0 = 1'b0; i_we0 = 1'b0; i_lock0 = 1'b0; i_addr0 = 32'h0; i_wdata0 = 32'h0;
    i_req1 = 1'b0; i_we1 = 1'b0; i_lock1 = 1'b0; i_addr1 = 32'h0; i_wdata1 = 32'h0;
    @(posedge clk);

    // Reset held with both requesting: no grants, no write enable
    step(1, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 0);
    step(1, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 0);

    // Tie after reset goes to requester 0, then requester 1
    step(0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 32'h20, 0, 0, 1);
    idle();

    // Requester 1 write, then requester 0 reads it back
    step(0, 0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h8, 32'h1234_5678, 0, 1);
    step(0, 1, 0, 0, 32'h8, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    idle();

    // Burst cap: make requester 1 last-served, then 4 locked grants to 0, then 1
    step(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(0, 1, 0, 1, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    step(0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    idle();

    // LOCK1 with requester 1 dropping out: dead cycle, then requester 0
    step(0, 0, 0, 0, 32'h0,  0, 1, 1, 1, 32'h40, 32'hCAFE_F00D, 0, 1);
    step(0, 1, 0, 0, 32'h10, 0, 1, 0, 1, 32'h40, 0, 0, 1);
    step(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    idle();

    // Reset in the middle of a locked read burst
    step(0, 1, 0, 1, 32'h8,  0, 0, 0, 0, 32'h0,  0, 1, 0);
    step(0, 1, 0, 1, 32'h8,  0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(1, 1, 0, 1, 32'h8,  0, 1, 0, 0, 32'h20, 0, 0, 0);
    step(0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 32'h20, 0, 0, 1);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/m_mem_arbiter.md
M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive locked grants to one requester while the other requester is waiting; legal range 1..15.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_req0 / i_req1  input  1  access request from requester 0 (CPU) / requester 1 (loader).
REQ-005 i_we0 / i_we1  input  1  1 = write, 0 = read; qualified by i_reqN.
REQ-006 i_lock0 / i_lock1  input  1  request to keep ownership for the following cycle (burst).
REQ-007 i_addr0 / i_addr1  input  32  byte address; passed to memory unmodified.
REQ-008 i_wdata0 / i_wdata1  input  32  write data.
REQ-009 o_gnt0 / o_gnt1  output  1  combinational grant; the access is performed at the rising edge that ends the cycle in which grant is high.
REQ-010 o_rdata0 / o_rdata1  output  32  registered read data.
REQ-011 o_rvalid0 / o_rvalid1  output  1  one-cycle pulse: o_rdataN is valid.
REQ-012 o_mem_we  output  1  memory write enable.
REQ-013 o_mem_addr / o_mem_wd  output  32  memory address / write data.
REQ-014 i_mem_rd  input  32  combinational memory read data for o_mem_addr.

Function
REQ-015 The block SHALL keep state {IDLE, LOCK0, LOCK1}, a last-served pointer (1 bit), and a 4-bit burst counter.
REQ-016 At most one of o_gnt0/o_gnt1 SHALL be high in any cycle, and a grant SHALL only be high when the matching i_reqN is high.
REQ-017 IDLE: a single requester SHALL be granted; if both request, the requester that is not the last-served one SHALL be granted.
REQ-018 In IDLE, when requester r is granted with i_lockr=1, the next state SHALL be LOCKr with counter=1; otherwise the state SHALL stay IDLE.
REQ-019 LOCKr: requester r SHALL be granted if i_reqr=1; the other requester SHALL NOT be granted, even if i_reqr=0.
REQ-020 LOCKr SHALL exit to IDLE when i_reqr=0, when i_lockr=0, or when counter==MAX_BURST while the other requester is requesting; otherwise the counter SHALL increment.
REQ-021 A forced exit at MAX_BURST SHALL make the other requester win the next IDLE tie (pointer=r).
REQ-022 The last-served pointer SHALL update to the granted index on every granted cycle.
REQ-023 With grant to requester g: o_mem_addr=i_addrg, o_mem_wd=i_wdatag, o_mem_we=i_weg. With no grant: all three SHALL be 0.
REQ-024 For a granted read, at the rising edge the block SHALL capture i_mem_rd into o_rdatag and assert o_rvalidg for exactly the next cycle. o_rdatag SHALL hold its value until the next granted read by g.
REQ-025 A granted write SHALL NOT assert o_rvalid. Write latency is the grant cycle, and read latency is 1 cycle after grant.
REQ-026 A requester SHALL hold i_req/i_we/i_addr/i_wdata stable until it sees its grant. The arbiter SHALL not queue requests.
REQ-027 Back-to-back grants to the same requester SHALL be allowed with one access per cycle and no bubble.
REQ-028 Addresses SHALL pass through without alignment or range checks; word alignment is the memory's job.

Reset
REQ-029 When i_reset=1 at a rising edge: state=IDLE, pointer=1 (requester 0 wins the first tie), counter=0, o_rvalid0/1=0, o_rdata0/1=0.
REQ-030 While i_reset=1: o_gnt0/1=0 and o_mem_we=0, regardless of requests.
REQ-031 Reset in LOCKr SHALL abort the burst; the in-flight read SHALL NOT produce o_rvalid.

Verification
REQ-032 Reset, then i_req0=i_req1=1 reads to 0x10/0x20 with memory holding 0xAAAA0000/0xBBBB0000 -> gnt0 cycle 1, gnt1 cycle 2; o_rdata0=0xAAAA0000 with rvalid0 in cycle 2; o_rdata1=0xBBBB0000 with rvalid1 in cycle 3.
REQ-033 Req1 write 0x8 data 0x12345678 alone -> o_mem_we=1, o_mem_addr=0x8 in the grant cycle; a subsequent req0 read of 0x8 returns 0x12345678; no rvalid1.
REQ-034 MAX_BURST=4, req0+lock0 held, req1 held -> gnt0 for 4 cycles, then gnt1 on the 5th cycle; gnt0 never coincides with gnt1.
REQ-035 LOCK1 active, i_req1 drops for one cycle while req0=1 -> no grant in that cycle; state IDLE; gnt0 the next cycle.
REQ-036 i_reset=1 asserted mid-burst during a read -> next cycle: no rvalid, o_rdata=0, grants 0; after release, tie goes to requester 0.
